tblink_rpc_invoke_dispatch: RTL and testbench
=============================================

Name: tblink_rpc_invoke_dispatch

Overview:
Hardware counterpart of the TbLink invoke path: accepts a stream of RPC invoke requests (method, call_id, blocking flag, params) and dispatches each to one of N BFM channels. It tracks outstanding calls in a tag table, accepts out-of-order channel responses, and merges them into one response stream carrying the original call_id. Blocking calls are gated by a run input, the hardware equivalent of "dispatcher running". The block sits between the endpoint transport and the per-interface BFMs.

Parameters:
N_CHANNELS, 4, number of BFM channels (1..16)
MAX_OUTSTANDING, 8, tag-table depth (power of 2, 2..64)
CALL_ID_W, 64, call_id width
METHOD_W, 8, method-id width
PARAM_W, 64, params/retval payload width
TAG_W, $clog2(MAX_OUTSTANDING), derived; not overridden

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high
run  in  1  1 = blocking calls may issue
req_valid  in  1  invoke request valid
req_ready  out  1  request accepted when valid&&ready
req_chan  in  4  target channel
req_method  in  METHOD_W  method id
req_call_id  in  CALL_ID_W  caller call_id
req_blocking  in  1  1 = blocking method
req_params  in  PARAM_W  packed params
ch_req_valid  out  N_CHANNELS  per-channel request valid
ch_req_ready  in  N_CHANNELS  per-channel ready
ch_req_method  out  N_CHANNELS*METHOD_W  flattened, channel i at [i*METHOD_W +: METHOD_W]
ch_req_params  out  N_CHANNELS*PARAM_W  flattened
ch_req_tag  out  N_CHANNELS*TAG_W  flattened
ch_rsp_valid  in  N_CHANNELS  channel response valid
ch_rsp_ready  out  N_CHANNELS  channel response accepted
ch_rsp_tag  in  N_CHANNELS*TAG_W  tag being answered
ch_rsp_retval  in  N_CHANNELS*PARAM_W  return value
rsp_valid  out  1  merged response valid
rsp_ready  in  1  merged response accepted
rsp_call_id  out  CALL_ID_W  original call_id
rsp_retval  out  PARAM_W  return value (0 on error)
rsp_error  out  1  1 = request rejected (bad channel)
outstanding  out  TAG_W+1  occupied table slots
blocked_cnt  out  16  saturating count of cycles a blocking call waited on run=0
err_bad_tag  out  1  sticky: response with FREE tag or channel mismatch

Behaviour:
- Reset: all valids 0, table all FREE, outstanding=0, blocked_cnt=0, err_bad_tag=0, arbiter pointer=0; in-flight state is discarded and channels are expected to reset together.
- Tag table: slot state FREE/ISSUED; stores call_id and chan. Allocation takes the lowest-index FREE slot.
- req_ready = (outstanding < MAX_OUTSTANDING) && (req_chan >= N_CHANNELS || channel i holding register empty). Uses the registered count; a same-cycle free gives no bypass.
- Channel holding register per channel: IDLE -> VALID on accept.
  - Non-blocking: ch_req_valid asserts the next cycle.
  - Blocking with run=0: stays HELD; blocked_cnt++ each cycle; HELD -> VALID once run=1.
  - VALID -> IDLE on ch_req_valid && ch_req_ready.
- Bad channel (req_chan >= N_CHANNELS): accepted; no slot is allocated; an error entry is loaded into a one-deep error register (req_ready is also gated on that register being empty). The merged response gets rsp_error=1, retval=0.
- Response merge: round-robin over N_CHANNELS channels plus the error source (index N).
  - The pointer advances past the winner.
  - The output register loads when empty or when draining that cycle; ch_rsp_ready is asserted only to the winner.
  - rsp_valid asserts the cycle after the winning handshake and holds stable until rsp_ready.
- A response whose tag is FREE, or whose slot chan differs, is consumed and dropped; err_bad_tag is set.
- The slot frees on response handshake; the freed slot is reusable the next cycle. Allocation and free in the same cycle net outstanding unchanged.
- Minimum latency: 1 cycle req->ch_req_valid, 1 cycle ch_rsp->rsp_valid.

Decomposition:
- Package tblink_rpc_dispatch_pkg: slot_state_e {FREE, ISSUED}, chan_state_e {IDLE, HELD, VALID}, a clog2-based tag-width helper, and the ERR_SRC index constant.
- Sub-module tblink_rpc_rr_arb: parametrised N-requester round-robin arbiter (req vector, advance strobe, one-hot grant).

Test Plan:
- Non-blocking call, chan 2, call_id 0x1234 -> ch_req_valid[2] next cycle with tag 0; channel returns retval 0xAB -> rsp call_id 0x1234, retval 0xAB, error 0, outstanding back to 0.
- Blocking call, chan 1, with run=0 for 5 cycles -> no ch_req_valid and blocked_cnt=5; req_ready=0 for chan 1; run=1 -> issued next cycle.
- 8 calls (ids 0..7) on chans 0..3 -> outstanding=8 and 9th req_ready=0; responses for tags 5 then 2 -> call_ids 5, 2 in that order; 9th accepted with tag 2.
- req_chan=5 with N_CHANNELS=4, call_id 0x77 -> rsp_error=1, retval 0, call_id 0x77, no slot used.
- All 4 channels and the error source assert responses together, rsp_ready toggling 1/0 -> grant order 0,1,2,3,err; no loss or duplication.
- Stray response with a FREE tag -> dropped, err_bad_tag=1. Reset with 3 outstanding -> all outputs at reset values, table FREE.

Source files
------------

// File: rtl/tblink_rpc_dispatch_pkg.sv
// Shared types and helpers for the TbLink RPC invoke dispatcher.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package tblink_rpc_dispatch_pkg;

    // Tag-table slot lifecycle: a slot is ISSUED from allocation until its response is consumed.
    typedef enum logic {
        FREE   = 1'b0,
        ISSUED = 1'b1
    } slot_state_e;

    // Per-channel holding register. HELD parks a blocking call while run=0.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        VALID = 2'd2
    } chan_state_e;

    // Width needed to address a table of 'depth' slots (never narrower than 1 bit).
    function automatic int tag_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // The error register is arbitrated as one extra requester placed after the last channel.
    localparam int ERR_SRC_OFFSET = 0;

    function automatic int err_src(input int n_channels);
        return n_channels + ERR_SRC_OFFSET;
    endfunction

endpackage

// File: rtl/tblink_rpc_rr_arb.sv
// Round-robin arbiter over N requesters with a one-hot grant.
// Latency: grant is combinational from req; pointer moves on the clock after adv.
// Backpressure: pointer only advances past the winner when adv is asserted.
module tblink_rpc_rr_arb #(
    parameter int N = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,   // request vector
    input  logic         adv,   // grant was consumed this cycle
    output logic [N-1:0] gnt    // one-hot grant
);

    localparam int PTR_W = (N <= 2) ? 1 : $clog2(N);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic             found;

    // First pass searches from the pointer upward, second pass wraps to index 0.
    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[k] && (k >= int'(ptr))) begin
                found   = 1'b1;
                gnt[k]  = 1'b1;
                ptr_nxt = (k == N - 1) ? '0 : PTR_W'(k + 1);
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!found && req[k]) begin
                found   = 1'b1;
                gnt[k]  = 1'b1;
                ptr_nxt = (k == N - 1) ? '0 : PTR_W'(k + 1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (adv && found) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/tblink_rpc_invoke_dispatch.sv
// Dispatches RPC invoke requests to N BFM channels and merges their out-of-order responses.
// Latency: 1 cycle req->ch_req_valid (non-blocking), 1 cycle ch_rsp->rsp_valid.
// Backpressure: req_ready drops on full tag table or busy target; responses stall while rsp holds.
// Ports: req_* invoke stream in; ch_req_*/ch_rsp_* flattened per-channel request/response;
//        rsp_* merged response out; outstanding/blocked_cnt/err_bad_tag status.
module tblink_rpc_invoke_dispatch
    import tblink_rpc_dispatch_pkg::*;
#(
    parameter int N_CHANNELS      = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CALL_ID_W       = 64,
    parameter int METHOD_W        = 8,
    parameter int PARAM_W         = 64,
    parameter int TAG_W           = tag_width(MAX_OUTSTANDING)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           run,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [3:0]                     req_chan,
    input  logic [METHOD_W-1:0]            req_method,
    input  logic [CALL_ID_W-1:0]           req_call_id,
    input  logic                           req_blocking,
    input  logic [PARAM_W-1:0]             req_params,
    output logic [N_CHANNELS-1:0]          ch_req_valid,
    input  logic [N_CHANNELS-1:0]          ch_req_ready,
    output logic [N_CHANNELS*METHOD_W-1:0] ch_req_method,
    output logic [N_CHANNELS*PARAM_W-1:0]  ch_req_params,
    output logic [N_CHANNELS*TAG_W-1:0]    ch_req_tag,
    input  logic [N_CHANNELS-1:0]          ch_rsp_valid,
    output logic [N_CHANNELS-1:0]          ch_rsp_ready,
    input  logic [N_CHANNELS*TAG_W-1:0]    ch_rsp_tag,
    input  logic [N_CHANNELS*PARAM_W-1:0]  ch_rsp_retval,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [CALL_ID_W-1:0]           rsp_call_id,
    output logic [PARAM_W-1:0]             rsp_retval,
    output logic                           rsp_error,
    output logic [TAG_W:0]                 outstanding,
    output logic [15:0]                    blocked_cnt,
    output logic                           err_bad_tag
);

    localparam int N_SRC   = N_CHANNELS + 1;
    localparam int ERR_SRC = err_src(N_CHANNELS);
    localparam int OUT_W   = TAG_W + 1;

    chan_state_e          ch_state     [N_CHANNELS];
    chan_state_e          ch_state_nxt [N_CHANNELS];
    logic [METHOD_W-1:0]  ch_method    [N_CHANNELS];
    logic [PARAM_W-1:0]   ch_params    [N_CHANNELS];
    logic [TAG_W-1:0]     ch_tag       [N_CHANNELS];

    slot_state_e          slot_state   [MAX_OUTSTANDING];
    logic [CALL_ID_W-1:0] slot_call_id [MAX_OUTSTANDING];
    logic [3:0]           slot_chan    [MAX_OUTSTANDING];

    logic                 err_vld;
    logic [CALL_ID_W-1:0] err_call_id;

    logic                  bad_chan, chan_idle, accept, alloc_en, hold_any;
    logic [TAG_W-1:0]      alloc_tag;
    logic [N_CHANNELS-1:0] ch_load;
    logic                  load_en, arb_adv, win_ch_hs, win_good, free_en, err_hs;
    logic [N_SRC-1:0]      arb_req, arb_gnt;
    logic [TAG_W-1:0]      win_tag;
    logic [3:0]            win_chan;
    logic [PARAM_W-1:0]    win_retval;

    // Request side: acceptance, lowest-free slot allocation, channel load strobes.
    always_comb begin
        bad_chan  = (int'(req_chan) >= N_CHANNELS);
        chan_idle = 1'b0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if ((req_chan == 4'(i)) && (ch_state[i] == IDLE)) chan_idle = 1'b1;
        end
        // Registered count only: a slot freed this cycle is not visible until the next one.
        req_ready = (outstanding < OUT_W'(MAX_OUTSTANDING)) && (bad_chan ? !err_vld : chan_idle);
        accept    = req_valid && req_ready;
        alloc_en  = accept && !bad_chan;
        alloc_tag = '0;
        for (int s = MAX_OUTSTANDING - 1; s >= 0; s--) begin
            if (slot_state[s] == FREE) alloc_tag = TAG_W'(s);
        end
        ch_load = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            ch_load[i] = alloc_en && (req_chan == 4'(i));
        end
    end

    // Channel holding-register next state and flattened channel request outputs.
    always_comb begin
        hold_any      = 1'b0;
        ch_req_valid  = '0;
        ch_req_method = '0;
        ch_req_params = '0;
        ch_req_tag    = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            ch_state_nxt[i] = ch_state[i];
            case (ch_state[i])
                IDLE:    if (ch_load[i]) ch_state_nxt[i] = (req_blocking && !run) ? HELD : VALID;
                HELD:    if (run) ch_state_nxt[i] = VALID;
                VALID:   if (ch_req_ready[i]) ch_state_nxt[i] = IDLE;
                default: ch_state_nxt[i] = IDLE;
            endcase
            if (ch_state[i] == HELD) hold_any = 1'b1;
            ch_req_valid[i]                         = (ch_state[i] == VALID);
            ch_req_method[i*METHOD_W +: METHOD_W]   = ch_method[i];
            ch_req_params[i*PARAM_W +: PARAM_W]     = ch_params[i];
            ch_req_tag[i*TAG_W +: TAG_W]            = ch_tag[i];
        end
    end

    // Response side: the merged output register refills when empty or draining.
    always_comb begin
        load_en      = !rsp_valid || rsp_ready;
        arb_req      = {err_vld, ch_rsp_valid};
        arb_adv      = load_en && (|arb_req);
        ch_rsp_ready = arb_gnt[N_CHANNELS-1:0] & {N_CHANNELS{load_en}};
        win_tag      = '0;
        win_chan     = '0;
        win_retval   = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (arb_gnt[i]) begin
                win_tag    = ch_rsp_tag[i*TAG_W +: TAG_W];
                win_chan   = 4'(i);
                win_retval = ch_rsp_retval[i*PARAM_W +: PARAM_W];
            end
        end
        win_ch_hs = |ch_rsp_ready;
        // A response is only trusted if its slot is live and was issued on this channel.
        win_good  = (slot_state[win_tag] == ISSUED) && (slot_chan[win_tag] == win_chan);
        free_en   = win_ch_hs && win_good;
        err_hs    = load_en && arb_gnt[ERR_SRC];
    end

    tblink_rpc_rr_arb #(.N(N_SRC)) u_arb (
        .clock (clock),
        .reset (reset),
        .req   (arb_req),
        .adv   (arb_adv),
        .gnt   (arb_gnt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                ch_state[i]  <= IDLE;
                ch_method[i] <= '0;
                ch_params[i] <= '0;
                ch_tag[i]    <= '0;
            end
            for (int s = 0; s < MAX_OUTSTANDING; s++) begin
                slot_state[s]   <= FREE;
                slot_call_id[s] <= '0;
                slot_chan[s]    <= '0;
            end
            err_vld     <= 1'b0;
            err_call_id <= '0;
            rsp_valid   <= 1'b0;
            rsp_call_id <= '0;
            rsp_retval  <= '0;
            rsp_error   <= 1'b0;
            outstanding <= '0;
            blocked_cnt <= '0;
            err_bad_tag <= 1'b0;
        end else begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                ch_state[i] <= ch_state_nxt[i];
                if (ch_load[i]) begin
                    ch_method[i] <= req_method;
                    ch_params[i] <= req_params;
                    ch_tag[i]    <= alloc_tag;
                end
            end
            // Alloc targets a FREE slot and free targets an ISSUED one, so they never collide.
            if (alloc_en) begin
                slot_state[alloc_tag]   <= ISSUED;
                slot_call_id[alloc_tag] <= req_call_id;
                slot_chan[alloc_tag]    <= req_chan;
            end
            if (free_en) slot_state[win_tag] <= FREE;

            case ({alloc_en, free_en})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: ;
            endcase

            if (hold_any && !run && (blocked_cnt != 16'hFFFF)) blocked_cnt <= blocked_cnt + 16'd1;

            if (accept && bad_chan) begin
                err_vld     <= 1'b1;
                err_call_id <= req_call_id;
            end else if (err_hs) begin
                err_vld <= 1'b0;
            end

            if (load_en) begin
                rsp_valid <= err_hs || free_en;
                if (err_hs) begin
                    rsp_call_id <= err_call_id;
                    rsp_retval  <= '0;
                    rsp_error   <= 1'b1;
                end else if (free_en) begin
                    rsp_call_id <= slot_call_id[win_tag];
                    rsp_retval  <= win_retval;
                    rsp_error   <= 1'b0;
                end
            end

            if (win_ch_hs && !win_good) err_bad_tag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tblink_rpc_invoke_dispatch.sv
// Self-checking bench for tblink_rpc_invoke_dispatch: directed scenarios then a random scoreboard run.
// Latency: n/a.
// Backpressure: exercises random ch_req_ready / rsp_ready stalls.
module tb_tblink_rpc_invoke_dispatch;

    localparam int N   = 4;
    localparam int MAX = 8;
    localparam int TW  = 3;

    logic           clock = 1'b0;
    logic           reset, run, req_valid, req_ready, req_blocking;
    logic [3:0]     req_chan;
    logic [7:0]     req_method;
    logic [63:0]    req_call_id, req_params;
    logic [N-1:0]   ch_req_valid, ch_req_ready, ch_rsp_valid, ch_rsp_ready;
    logic [N*8-1:0] ch_req_method;
    logic [N*64-1:0] ch_req_params, ch_rsp_retval;
    logic [N*TW-1:0] ch_req_tag, ch_rsp_tag;
    logic           rsp_valid, rsp_ready, rsp_error, err_bad_tag;
    logic [63:0]    rsp_call_id, rsp_retval;
    logic [TW:0]    outstanding;
    logic [15:0]    blocked_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    tblink_rpc_invoke_dispatch dut (
        .clock(clock), .reset(reset), .run(run),
        .req_valid(req_valid), .req_ready(req_ready), .req_chan(req_chan),
        .req_method(req_method), .req_call_id(req_call_id), .req_blocking(req_blocking),
        .req_params(req_params),
        .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready), .ch_req_method(ch_req_method),
        .ch_req_params(ch_req_params), .ch_req_tag(ch_req_tag),
        .ch_rsp_valid(ch_rsp_valid), .ch_rsp_ready(ch_rsp_ready), .ch_rsp_tag(ch_rsp_tag),
        .ch_rsp_retval(ch_rsp_retval),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_call_id(rsp_call_id),
        .rsp_retval(rsp_retval), .rsp_error(rsp_error),
        .outstanding(outstanding), .blocked_cnt(blocked_cnt), .err_bad_tag(err_bad_tag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        run = 1'b1; req_valid = 1'b0; req_chan = '0; req_method = '0; req_call_id = '0;
        req_blocking = 1'b0; req_params = '0; ch_req_ready = '0; ch_rsp_valid = '0;
        ch_rsp_tag = '0; ch_rsp_retval = '0; rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_req(input int ch, input logic [63:0] id, input logic blk);
        req_chan = 4'(ch); req_call_id = id; req_blocking = blk;
        req_method = 8'(id + 64'h10); req_params = id ^ 64'h5555_0000_0000_5555;
        req_valid = 1'b1;
        #1;
        check("req_ready_accept", 64'(req_ready), 64'(1));
        tick();
        req_valid = 1'b0;
    endtask

    task automatic chan_take(input int ch, input int exp_tag);
        int k = 0;
        while (!ch_req_valid[ch] && k < 10) begin tick(); k++; end
        check("ch_req_valid", 64'(ch_req_valid[ch]), 64'(1));
        check("ch_req_tag", 64'(ch_req_tag[ch*TW +: TW]), 64'(exp_tag));
        ch_req_ready[ch] = 1'b1;
        tick();
        ch_req_ready[ch] = 1'b0;
    endtask

    task automatic chan_rsp(input int ch, input int tag, input logic [63:0] rv);
        logic done = 1'b0;
        ch_rsp_valid[ch] = 1'b1;
        ch_rsp_tag[ch*TW +: TW] = TW'(tag);
        ch_rsp_retval[ch*64 +: 64] = rv;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            done = ch_rsp_ready[ch];
            tick();
        end
        ch_rsp_valid[ch] = 1'b0;
        check("ch_rsp_handshake", 64'(done), 64'(1));
    endtask

    task automatic drain_rsp(input logic [63:0] id, input logic [63:0] rv, input logic err);
        int k = 0;
        while (!rsp_valid && k < 10) begin tick(); k++; end
        check("rsp_valid", 64'(rsp_valid), 64'(1));
        check("rsp_call_id", rsp_call_id, id);
        check("rsp_retval", rsp_retval, rv);
        check("rsp_error", 64'(rsp_error), 64'(err));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Reference model state for the random run
    bit          m_busy [MAX];
    logic [63:0] m_call [MAX];
    int          m_cnt;
    logic [63:0] exp_ret [logic [63:0]];
    bit          exp_err [logic [63:0]];
    int          chq_tag  [N][$];
    logic [7:0]  chq_meth [N][$];
    logic [63:0] chq_par  [N][$];
    int          pend [N][$];
    int          cur_tag [N];

    initial begin
        logic [63:0] got_id [$];
        logic [63:0] got_rv [$];
        logic [N-1:0] chs;
        logic [N-1:0] rsp_hs_ch;
        logic [63:0] id;
        int t;
        int seq;

        // ---- reset state
        do_reset();
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_ch_req_valid", 64'(ch_req_valid), 64'(0));
        check("rst_outstanding", 64'(outstanding), 64'(0));
        check("rst_blocked_cnt", 64'(blocked_cnt), 64'(0));
        check("rst_err_bad_tag", 64'(err_bad_tag), 64'(0));

        // ---- non-blocking call on channel 2
        do_req(2, 64'h1234, 1'b0);
        check("nb_ch_req_valid", 64'(ch_req_valid), 64'(4'b0100));
        check("nb_outstanding", 64'(outstanding), 64'(1));
        check("nb_method", 64'(ch_req_method[2*8 +: 8]), 64'(8'h44));
        check("nb_params", ch_req_params[2*64 +: 64], 64'h5555_0000_0000_4761);
        chan_take(2, 0);
        chan_rsp(2, 0, 64'hAB);
        check("nb_rsp_latency", 64'(rsp_valid), 64'(1));
        check("nb_outstanding_free", 64'(outstanding), 64'(0));
        drain_rsp(64'h1234, 64'hAB, 1'b0);

        // ---- blocking call held by run=0
        run = 1'b0;
        do_req(1, 64'h22, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        check("blk_no_valid", 64'(ch_req_valid), 64'(0));
        check("blk_cnt", 64'(blocked_cnt), 64'(5));
        req_chan = 4'd1; req_valid = 1'b1;
        #1;
        check("blk_req_ready", 64'(req_ready), 64'(0));
        req_valid = 1'b0; run = 1'b1;
        tick();
        check("blk_issue", 64'(ch_req_valid), 64'(4'b0010));
        check("blk_cnt_hold", 64'(blocked_cnt), 64'(5));
        chan_take(1, 0);
        chan_rsp(1, 0, 64'h99);
        drain_rsp(64'h22, 64'h99, 1'b0);

        // ---- fill the table, out-of-order responses, reuse of freed slot
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_req(i % 4, 64'(i), 1'b0);
            chan_take(i % 4, i);
        end
        check("full_outstanding", 64'(outstanding), 64'(8));
        req_chan = 4'd0; req_call_id = 64'd8; req_valid = 1'b1;
        #1;
        check("full_req_ready", 64'(req_ready), 64'(0));
        req_valid = 1'b0;
        chan_rsp(1, 5, 64'h505);
        drain_rsp(64'd5, 64'h505, 1'b0);
        chan_rsp(2, 2, 64'h202);
        drain_rsp(64'd2, 64'h202, 1'b0);
        do_req(0, 64'd8, 1'b0);
        chan_take(0, 2);
        check("reuse_outstanding", 64'(outstanding), 64'(7));

        // ---- bad channel
        do_reset();
        do_req(5, 64'h77, 1'b0);
        check("bad_no_slot", 64'(outstanding), 64'(0));
        drain_rsp(64'h77, 64'h0, 1'b1);
        check("bad_no_slot_after", 64'(outstanding), 64'(0));

        // ---- all sources at once with rsp_ready toggling
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_req(i, 64'h100 + 64'(i), 1'b0);
            chan_take(i, i);
        end
        do_req(5, 64'h1FF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ch_rsp_valid[i] = 1'b1;
            ch_rsp_tag[i*TW +: TW] = TW'(i);
            ch_rsp_retval[i*64 +: 64] = 64'hF00 + 64'(i);
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && got_id.size() < 5; c++) begin
            #1;
            chs = ch_rsp_valid & ch_rsp_ready;
            if (rsp_valid && rsp_ready) begin
                got_id.push_back(rsp_call_id);
                got_rv.push_back(rsp_retval);
            end
            tick();
            ch_rsp_valid = ch_rsp_valid & ~chs;
            rsp_ready = ~rsp_ready;
        end
        rsp_ready = 1'b0;
        check("rr_count", 64'(got_id.size()), 64'(5));
        for (int k = 0; k < 5 && k < got_id.size(); k++) begin
            check("rr_order", got_id[k], (k == 4) ? 64'h1FF : 64'h100 + 64'(k));
            check("rr_retval", got_rv[k], (k == 4) ? 64'h0 : 64'hF00 + 64'(k));
        end
        check("rr_outstanding", 64'(outstanding), 64'(0));
        check("rr_rsp_empty", 64'(rsp_valid), 64'(0));

        // ---- stray response on a FREE tag
        chan_rsp(0, 6, 64'hDEAD);
        check("stray_err_bad_tag", 64'(err_bad_tag), 64'(1));
        check("stray_dropped", 64'(rsp_valid), 64'(0));

        // ---- reset with calls in flight
        do_req(0, 64'h300, 1'b0);
        do_req(1, 64'h301, 1'b1);
        do_req(2, 64'h302, 1'b0);
        check("inflight_outstanding", 64'(outstanding), 64'(3));
        check("inflight_valid", 64'(ch_req_valid), 64'(4'b0111));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_ch_req_valid", 64'(ch_req_valid), 64'(0));
        check("rst2_outstanding", 64'(outstanding), 64'(0));
        check("rst2_err_bad_tag", 64'(err_bad_tag), 64'(0));
        check("rst2_rsp_valid", 64'(rsp_valid), 64'(0));
        do_req(3, 64'h400, 1'b0);
        chan_take(3, 0);

        // ---- random run against the scoreboard model
        do_reset();
        m_cnt = 0;
        seq = 0;
        for (int s = 0; s < MAX; s++) m_busy[s] = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            seq++;
            req_valid    = (cyc < 3000) && ($urandom_range(0, 2) == 0);
            req_chan     = 4'($urandom_range(0, 5));
            req_call_id  = {32'hCA11_0000, 32'(seq)};
            req_method   = 8'($urandom);
            req_params   = {$urandom, $urandom};
            req_blocking = 1'($urandom);
            run          = (cyc >= 3000) || ($urandom_range(0, 3) != 0);
            ch_req_ready = 4'($urandom);
            rsp_ready    = 1'($urandom);
            for (int i = 0; i < N; i++) begin
                if (!ch_rsp_valid[i] && pend[i].size() > 0 && $urandom_range(0, 1) == 1) begin
                    cur_tag[i] = pend[i][$urandom_range(0, pend[i].size() - 1)];
                    ch_rsp_tag[i*TW +: TW] = TW'(cur_tag[i]);
                    ch_rsp_retval[i*64 +: 64] = {$urandom, $urandom};
                    ch_rsp_valid[i] = 1'b1;
                end
            end

            @(negedge clock);
            check("one_rsp_grant", 64'($countones(ch_rsp_ready) <= 1), 64'(1));
            // channel requests issued this edge
            for (int i = 0; i < N; i++) begin
                if (ch_req_valid[i] && ch_req_ready[i]) begin
                    check("ch_req_expected", 64'(chq_tag[i].size() != 0), 64'(1));
                    if (chq_tag[i].size() != 0) begin
                        t = chq_tag[i].pop_front();
                        check("r_ch_req_tag", 64'(ch_req_tag[i*TW +: TW]), 64'(t));
                        check("r_ch_req_method", 64'(ch_req_method[i*8 +: 8]), 64'(chq_meth[i].pop_front()));
                        check("r_ch_req_params", ch_req_params[i*64 +: 64], chq_par[i].pop_front());
                        pend[i].push_back(t);
                    end
                end
            end
            // new request: allocation sees the table before this cycle's frees
            if (req_valid && m_cnt >= MAX) check("r_req_ready_full", 64'(req_ready), 64'(0));
            if (req_valid && req_ready) begin
                if (int'(req_chan) >= N) begin
                    exp_ret[req_call_id] = 64'h0;
                    exp_err[req_call_id] = 1'b1;
                end else begin
                    t = -1;
                    for (int s = MAX - 1; s >= 0; s--) if (!m_busy[s]) t = s;
                    if (t >= 0) begin
                        m_busy[t] = 1'b1;
                        m_call[t] = req_call_id;
                        m_cnt++;
                        chq_tag[req_chan].push_back(t);
                        chq_meth[req_chan].push_back(req_method);
                        chq_par[req_chan].push_back(req_params);
                    end
                end
            end
            // channel responses consumed this edge
            rsp_hs_ch = ch_rsp_valid & ch_rsp_ready;
            for (int i = 0; i < N; i++) begin
                if (rsp_hs_ch[i]) begin
                    t = cur_tag[i];
                    for (int k = pend[i].size() - 1; k >= 0; k--) if (pend[i][k] == t) pend[i].delete(k);
                    check("r_rsp_tag_live", 64'(m_busy[t]), 64'(1));
                    exp_ret[m_call[t]] = ch_rsp_retval[i*64 +: 64];
                    exp_err[m_call[t]] = 1'b0;
                    m_busy[t] = 1'b0;
                    m_cnt--;
                end
            end
            // merged response consumed this edge
            if (rsp_valid && rsp_ready) begin
                id = rsp_call_id;
                check("r_rsp_known", 64'(exp_ret.exists(id)), 64'(1));
                if (exp_ret.exists(id)) begin
                    check("r_rsp_retval", rsp_retval, exp_ret[id]);
                    check("r_rsp_error", 64'(rsp_error), 64'(exp_err[id]));
                    exp_ret.delete(id);
                    exp_err.delete(id);
                end
            end

            tick();
            ch_rsp_valid = ch_rsp_valid & ~rsp_hs_ch;
            check("r_outstanding", 64'(outstanding), 64'(m_cnt));
        end
        check("r_all_responded", 64'(exp_ret.num()), 64'(0));
        check("r_model_empty", 64'(m_cnt), 64'(0));
        check("r_no_bad_tag", 64'(err_bad_tag), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
